// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage access controller: op codes, FSM states,
// big-endian byte-lane selects and reset/write constants.
package mem_access_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [3:0]  SEL_B0    = 4'b1000;
    localparam logic [3:0]  SEL_B1    = 4'b0100;
    localparam logic [3:0]  SEL_B2    = 4'b0010;
    localparam logic [3:0]  SEL_B3    = 4'b0001;
    localparam logic [3:0]  SEL_H0    = 4'b1100;
    localparam logic [3:0]  SEL_H1    = 4'b0011;
    localparam logic [3:0]  SEL_W     = 4'b1111;
    localparam logic [3:0]  SEL_NONE  = 4'b0000;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic        RST_LVL   = 1'b1;
    localparam logic        WE_WRITE  = 1'b1;
    localparam logic        WE_READ   = 1'b0;

    // Big-endian: byte offset 0 lives in bits 31:24.
    function automatic logic [3:0] byte_sel(input logic [1:0] a);
        logic [3:0] s;
        case (a)
            2'b00:   s = SEL_B0;
            2'b01:   s = SEL_B1;
            2'b10:   s = SEL_B2;
            default: s = SEL_B3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Selects the addressed byte/halfword of a big-endian read word and
// sign- or zero-extends it according to the load op. Purely combinational.
module mem_access_ctrl_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (addr_lo)
            2'b00:   b = rdata[31:24];
            2'b01:   b = rdata[23:16];
            2'b10:   b = rdata[15:8];
            default: b = rdata[7:0];
        endcase
        h = addr_lo[1] ? rdata[15:0] : rdata[31:16];

        case (op)
            OP_LB:   data = {{24{b[7]}}, b};
            OP_LBU:  data = {24'h000000, b};
            OP_LH:   data = {{16{h[15]}}, h};
            OP_LHU:  data = {16'h0000, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM stage: forwards ALU results to write-back, or runs a req/ack bus access
// for loads/stores while stalling upstream, with alignment and timeout checks.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_store_data,
    output logic        stall_req,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        addr_err,
    output logic        bus_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [4:0]  wb_wd_q, wb_wd_d;
    logic        wb_wreg_q, wb_wreg_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic        addr_err_q, addr_err_d, bus_err_q, bus_err_d;

    logic        is_mem, is_load, misalign;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c, load_data;

    mem_access_ctrl_load_align u_load_align (
        .op      (mem_op),
        .addr_lo (mem_addr[1:0]),
        .rdata   (bus_rdata),
        .data    (load_data)
    );

    always_comb begin
        is_mem   = 1'b1;
        is_load  = 1'b0;
        misalign = 1'b0;
        sel_c    = SEL_NONE;
        wdata_c  = ZERO_WORD;
        case (mem_op)
            OP_LB, OP_LBU: begin
                is_load = 1'b1;
                sel_c   = byte_sel(mem_addr[1:0]);
            end
            OP_LH, OP_LHU: begin
                is_load  = 1'b1;
                misalign = mem_addr[0];
                sel_c    = mem_addr[1] ? SEL_H1 : SEL_H0;
            end
            OP_LW: begin
                is_load  = 1'b1;
                misalign = |mem_addr[1:0];
                sel_c    = SEL_W;
            end
            OP_SB: begin
                sel_c   = byte_sel(mem_addr[1:0]);
                wdata_c = {4{mem_store_data[7:0]}};
            end
            OP_SH: begin
                misalign = mem_addr[0];
                sel_c    = mem_addr[1] ? SEL_H1 : SEL_H0;
                wdata_c  = {2{mem_store_data[15:0]}};
            end
            OP_SW: begin
                misalign = |mem_addr[1:0];
                sel_c    = SEL_W;
                wdata_c  = mem_store_data;
            end
            default: is_mem = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        wb_wd_d     = wb_wd_q;
        wb_wreg_d   = wb_wreg_q;
        wb_wdata_d  = wb_wdata_q;
        addr_err_d  = 1'b0;
        bus_err_d   = 1'b0;
        stall_req   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!is_mem) begin
                    wb_wd_d    = mem_wd;
                    wb_wreg_d  = mem_wreg;
                    wb_wdata_d = mem_wdata;
                end else if (misalign) begin
                    wb_wreg_d  = 1'b0;
                    addr_err_d = 1'b1;
                end else begin
                    stall_req   = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_load ? WE_READ : WE_WRITE;
                    bus_addr_d  = {mem_addr[31:2], 2'b00};
                    bus_sel_d   = sel_c;
                    bus_wdata_d = wdata_c;
                    cnt_d       = 8'd0;
                    wb_wreg_d   = 1'b0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Ack is tested first so it wins over a coincident timeout.
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_IDLE;
                    if (is_load) begin
                        wb_wd_d    = mem_wd;
                        wb_wreg_d  = mem_wreg;
                        wb_wdata_d = load_data;
                    end else begin
                        wb_wreg_d = 1'b0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    wb_wreg_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    stall_req = 1'b1;
                    wb_wreg_d = 1'b0;
                    cnt_d     = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_LVL) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= ZERO_WORD;
            bus_sel_q   <= SEL_NONE;
            bus_wdata_q <= ZERO_WORD;
            wb_wd_q     <= REG_ZERO;
            wb_wreg_q   <= 1'b0;
            wb_wdata_q  <= ZERO_WORD;
            addr_err_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            wb_wd_q     <= wb_wd_d;
            wb_wreg_q   <= wb_wreg_d;
            wb_wdata_q  <= wb_wdata_d;
            addr_err_q  <= addr_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_sel   = bus_sel_q;
    assign bus_wdata = bus_wdata_q;
    assign wb_wd     = wb_wd_q;
    assign wb_wreg   = wb_wreg_q;
    assign wb_wdata  = wb_wdata_q;
    assign addr_err  = addr_err_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: pass-through, loads/stores with delayed
// acks, misalignment, timeout, ack-vs-timeout race and reset mid-access.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_store_data;
    logic        stall_req;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        addr_err;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_sel;
    logic        cap_we;
    int          stalls, reqs;
    logic        done;

    mem_access_ctrl #(.TIMEOUT(15)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_wd         (mem_wd),
        .mem_wreg       (mem_wreg),
        .mem_wdata      (mem_wdata),
        .mem_op         (mem_op),
        .mem_addr       (mem_addr),
        .mem_store_data (mem_store_data),
        .stall_req      (stall_req),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_sel        (bus_sel),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .bus_ack        (bus_ack),
        .wb_wd          (wb_wd),
        .wb_wreg        (wb_wreg),
        .wb_wdata       (wb_wdata),
        .addr_err       (addr_err),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one memory access whose op/addr are already on the inputs. The ack is
    // raised in BUSY cycle number `waits` (0 = first BUSY cycle) when ack_en.
    task automatic do_access(input int waits, input logic [31:0] rdata, input logic ack_en);
        stalls = 0;
        reqs   = 0;
        done   = 1'b0;
        #1;
        if (stall_req) stalls++;
        step();
        for (int i = 0; i < 40; i++) begin
            if (ack_en && i == waits) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata;
            end
            #1;
            if (i == 0) begin
                cap_addr  = bus_addr;
                cap_sel   = bus_sel;
                cap_we    = bus_we;
                cap_wdata = bus_wdata;
            end
            if (bus_req) reqs++;
            if (stall_req) stalls++;
            done = !stall_req;
            step();
            bus_ack   = 1'b0;
            bus_rdata = 32'h0;
            if (done) break;
        end
        chk("access_completes_in_budget", {31'b0, done}, 32'd1);
        mem_op   = 4'd0;
        mem_wreg = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        mem_wd         = 5'd0;
        mem_wreg       = 1'b0;
        mem_wdata      = 32'h0;
        mem_op         = 4'd0;
        mem_addr       = 32'h0;
        mem_store_data = 32'h0;
        bus_rdata      = 32'h0;
        bus_ack        = 1'b0;
        step();
        step();
        chk("rst_bus_req",  {31'b0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_sel",  {28'b0, bus_sel}, 32'd0);
        chk("rst_wb_wreg",  {31'b0, wb_wreg}, 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'h0);
        chk("rst_errs",     {30'b0, addr_err, bus_err}, 32'd0);
        chk("rst_stall",    {31'b0, stall_req}, 32'd0);
        rst = 1'b0;

        // ALU pass-through
        mem_op = 4'd0; mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h1234_5678;
        #1;
        chk("alu_stall", {31'b0, stall_req}, 32'd0);
        step();
        chk("alu_wb_wd",    {27'b0, wb_wd}, 32'd5);
        chk("alu_wb_wreg",  {31'b0, wb_wreg}, 32'd1);
        chk("alu_wb_wdata", wb_wdata, 32'h1234_5678);

        // Ack while IDLE is ignored
        mem_wd = 5'd6; mem_wdata = 32'hCAFE_0001; bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        chk("idle_ack_bus_req", {31'b0, bus_req}, 32'd0);
        chk("idle_ack_wdata",   wb_wdata, 32'hCAFE_0001);

        // LB at 0x1001, ack after 3 waits
        mem_op = 4'd1; mem_addr = 32'h0000_1001; mem_wd = 5'd7; mem_wreg = 1'b1;
        do_access(3, 32'h1180_2233, 1'b1);
        chk("lb_addr",   cap_addr, 32'h0000_1000);
        chk("lb_sel",    {28'b0, cap_sel}, 32'h4);
        chk("lb_we",     {31'b0, cap_we}, 32'd0);
        chk("lb_stalls", stalls, 32'd4);
        chk("lb_wdata",  wb_wdata, 32'hFFFF_FF80);
        chk("lb_wreg",   {31'b0, wb_wreg}, 32'd1);
        chk("lb_wd",     {27'b0, wb_wd}, 32'd7);
        chk("lb_req_dropped", {31'b0, bus_req}, 32'd0);

        // Same access as LBU
        mem_op = 4'd2; mem_addr = 32'h0000_1001; mem_wd = 5'd8; mem_wreg = 1'b1;
        do_access(3, 32'h1180_2233, 1'b1);
        chk("lbu_wdata", wb_wdata, 32'h0000_0080);
        chk("lbu_wreg",  {31'b0, wb_wreg}, 32'd1);

        // SH at 0x2002, one wait
        mem_op = 4'd7; mem_addr = 32'h0000_2002; mem_store_data = 32'hAAAA_BEEF; mem_wreg = 1'b1;
        do_access(1, 32'h0, 1'b1);
        chk("sh_we",     {31'b0, cap_we}, 32'd1);
        chk("sh_sel",    {28'b0, cap_sel}, 32'h3);
        chk("sh_wdata",  cap_wdata, 32'hBEEF_BEEF);
        chk("sh_addr",   cap_addr, 32'h0000_2000);
        chk("sh_stalls", stalls, 32'd2);
        chk("sh_wreg",   {31'b0, wb_wreg}, 32'd0);

        // SB at 0x5003, ack in first BUSY cycle
        mem_op = 4'd6; mem_addr = 32'h0000_5003; mem_store_data = 32'h1234_56A5;
        do_access(0, 32'h0, 1'b1);
        chk("sb_sel",    {28'b0, cap_sel}, 32'h1);
        chk("sb_wdata",  cap_wdata, 32'hA5A5_A5A5);
        chk("sb_stalls", stalls, 32'd1);

        // LH at 0x6002 sign-extends the low halfword
        mem_op = 4'd3; mem_addr = 32'h0000_6002; mem_wd = 5'd9; mem_wreg = 1'b1;
        do_access(0, 32'h1234_8001, 1'b1);
        chk("lh_sel",   {28'b0, cap_sel}, 32'h3);
        chk("lh_wdata", wb_wdata, 32'hFFFF_8001);

        // Misaligned LW
        mem_op = 4'd5; mem_addr = 32'h0000_3002; mem_wd = 5'd10; mem_wreg = 1'b1;
        #1;
        chk("mis_stall", {31'b0, stall_req}, 32'd0);
        step();
        chk("mis_addr_err", {31'b0, addr_err}, 32'd1);
        chk("mis_bus_req",  {31'b0, bus_req}, 32'd0);
        chk("mis_wreg",     {31'b0, wb_wreg}, 32'd0);
        mem_op = 4'd0; mem_wreg = 1'b0;
        step();
        chk("mis_pulse_end", {31'b0, addr_err}, 32'd0);

        // LW with no ack -> timeout
        mem_op = 4'd5; mem_addr = 32'h0000_7000; mem_wd = 5'd11; mem_wreg = 1'b1;
        do_access(0, 32'h0, 1'b0);
        chk("to_req_cycles", reqs, 32'd15);
        chk("to_stalls",     stalls, 32'd15);
        chk("to_bus_err",    {31'b0, bus_err}, 32'd1);
        chk("to_bus_req",    {31'b0, bus_req}, 32'd0);
        chk("to_wreg",       {31'b0, wb_wreg}, 32'd0);
        step();
        chk("to_pulse_end",  {31'b0, bus_err}, 32'd0);

        // Ack on the final timeout cycle wins
        mem_op = 4'd5; mem_addr = 32'h0000_7004; mem_wd = 5'd12; mem_wreg = 1'b1;
        do_access(14, 32'hDEAD_BEEF, 1'b1);
        chk("race_bus_err", {31'b0, bus_err}, 32'd0);
        chk("race_wreg",    {31'b0, wb_wreg}, 32'd1);
        chk("race_wdata",   wb_wdata, 32'hDEAD_BEEF);
        chk("race_stalls",  stalls, 32'd15);

        // Reset in the middle of a BUSY access
        mem_op = 4'd5; mem_addr = 32'h0000_8000; mem_wd = 5'd13; mem_wreg = 1'b1;
        step();
        chk("rbusy_req_up", {31'b0, bus_req}, 32'd1);
        rst = 1'b1; mem_op = 4'd0; mem_wreg = 1'b0;
        step();
        chk("rbusy_req",   {31'b0, bus_req}, 32'd0);
        chk("rbusy_wreg",  {31'b0, wb_wreg}, 32'd0);
        chk("rbusy_stall", {31'b0, stall_req}, 32'd0);
        rst = 1'b0;
        step();
        chk("rbusy_idle_stall", {31'b0, stall_req}, 32'd0);
        chk("rbusy_idle_req",   {31'b0, bus_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
